buzzer_led_driver: RTL and testbench
====================================

# buzzer_led_driver

Three-channel RGB LED blink engine that sits directly downstream of the buzzer AXI-Lite register block. Consumes per-channel mode/enable/hold/duration configuration and the software reset, drives the three board LED pins, and returns per-channel LED status for software readback. One identical channel engine per colour, each with its own state machine and interval counter.

## Interface
- CNT_WIDTH, 32: width of duration inputs and interval counters.
- aclk  in  1  clock.
- aresetn  in  1  reset; synchronous, active-low.
- user_resetn  in  1  software reset from register block; synchronous, active-low; same effect as aresetn.
- mode_r / mode_g / mode_b  in  1 each  0 = constant on, 1 = blinking.
- enable_r / enable_g / enable_b  in  1 each  channel enable.
- holded_r / holded_g / holded_b  in  1 each  when the channel is disabled: 1 = freeze the current LED level, 0 = LED off.
- duration_r / duration_g / duration_b  in  CNT_WIDTH each  blink half-period in aclk cycles.
- led_r / led_g / led_b  out  1 each  LED pin drive.
- led_r_sts / led_g_sts / led_b_sts  out  1 each  logical LED state (1 = lit), fed back to the register block.

## Operation
- Per-channel states: OFF, ON_CONST, BLINK_ON, BLINK_OFF, HOLD.
- Effective half-period deff = max(duration, 1); duration 0 behaves as 1.
- Transitions are evaluated every cycle, in this priority order:
  - reset (aresetn=0 or user_resetn=0) → OFF, counter=0.
  - enable=0 and holded=0 → OFF.
  - enable=0 and holded=1 → HOLD; the LED level is latched from the state it leaves. Entry from OFF latches 0.
  - enable=1, mode=0 → ON_CONST, counter=0.
  - enable=1, mode=1, from OFF/ON_CONST/HOLD → BLINK_ON, counter=0.
  - BLINK_ON/BLINK_OFF: counter increments each cycle. When counter ≥ deff−1, toggle to the other blink state and clear the counter.
- Comparison is ≥, so lowering duration below the current count forces a toggle on the next cycle. Raising duration extends the current phase.
- HOLD with enable=0: the latched level stays fixed. The counter stays frozen and is not used on exit.
- The counter never wraps: the maximum count is 2^CNT_WIDTH−2 before toggle.
- Logical LED level: OFF=0, ON_CONST=1, BLINK_ON=1, BLINK_OFF=0, HOLD=latched.
- led_x_sts = logical level; led_x = logical level (or inverted, see Configuration).
- Channels are fully independent; simultaneous config changes on different channels do not interact.

## Timing
- All outputs are registered. Reset values: led_x_sts=0; led_x=0 (1 with active-low build); state OFF; counters 0.
- Config input change → led/led_sts change: 1 cycle latency.
- Blink waveform: exactly deff cycles high, then deff cycles low, repeating. The first high phase starts 1 cycle after enable/mode qualifies.
- Reset applied mid-blink: outputs reach the reset value on the next clock edge. On release, the channel re-enters per its inputs; the first blink phase is BLINK_ON with a full deff.
- Config inputs are sampled every cycle; they are static registers in the aclk domain, so no synchronisers are needed.

## Configuration
- BUZZER_LED_ACTIVE_LOW_EN defined: led_x = ~logical level, for boards with active-low LEDs; reset drives led_x=1. led_x_sts is unaffected (1 = lit).
- Not defined: led_x = logical level; reset drives led_x=0.

## Structure
- Shared package buzzer_pkg:
  - typedef enum led_state_t {OFF, ON_CONST, BLINK_ON, BLINK_OFF, HOLD};
  - localparam BUZZER_CNT_WIDTH = 32.
- Sub-module buzzer_led_channel: one state machine, counter and hold latch. Instantiated three times by buzzer_led_driver, which only adds output polarity handling.

## Test plan
- Reset check: hold aresetn=0 with enable_r=1, mode_r=0 → led_r_sts=0. Release → led_r_sts=1 one cycle later.
- Blink: enable_g=1, mode_g=1, duration_g=4 → led_g_sts sequence 4 high / 4 low, repeating; 1-cycle start latency.
- Degenerate duration: duration_b=0, then 1, in blink mode → toggles every cycle in both cases.
- Hold: blink with duration_r=10, drop enable_r with holded_r=1 while lit → led_r_sts stays 1 indefinitely. Same with holded_r=0 → led_r_sts=0 next cycle.
- Shrink duration mid-phase: duration_g 100→3 at count 50 → toggle on the next cycle, then 3/3 cadence.
- user_resetn pulse mid-blink on all channels → all led_x_sts=0 next cycle; restart in BLINK_ON with a full period. Rerun with BUZZER_LED_ACTIVE_LOW_EN and check led_x = ~led_x_sts.

Source files
------------

// File: rtl/buzzer_pkg.sv
// Shared types and sizing for the buzzer LED blink engine.
// BUZZER_LED_ACTIVE_LOW_EN selects active-low LED pins in the top.
package buzzer_pkg;

  typedef enum logic [2:0] {
    OFF,
    ON_CONST,
    BLINK_ON,
    BLINK_OFF,
    HOLD
  } led_state_t;

  localparam int BUZZER_CNT_WIDTH = 32;

endpackage

// File: rtl/buzzer_led_channel.sv
// One LED channel: state machine, interval counter and hold latch.
// lvl_q is both the registered LED level and the HOLD latch.
module buzzer_led_channel
  import buzzer_pkg::*;
#(
  parameter int CNT_WIDTH = BUZZER_CNT_WIDTH
) (
  input  logic                 aclk,
  input  logic                 aresetn,
  input  logic                 user_resetn,
  input  logic                 mode,
  input  logic                 enable,
  input  logic                 holded,
  input  logic [CNT_WIDTH-1:0] duration,
  output logic                 led_sts
);

  led_state_t           state_q, state_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic [CNT_WIDTH-1:0] last;
  logic                 lvl_q, lvl_d;

  // Final count of a phase; duration 0 behaves like 1.
  always_comb begin
    last = '0;
    if (duration != '0) begin
      last = duration - CNT_WIDTH'(1);
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    lvl_d   = lvl_q;
    if (!aresetn || !user_resetn) begin
      state_d = OFF;
      cnt_d   = '0;
      lvl_d   = 1'b0;
    end else if (!enable && !holded) begin
      state_d = OFF;
      cnt_d   = '0;
      lvl_d   = 1'b0;
    end else if (!enable) begin
      state_d = HOLD;
    end else if (!mode) begin
      state_d = ON_CONST;
      cnt_d   = '0;
      lvl_d   = 1'b1;
    end else begin
      unique case (state_q)
        BLINK_ON: begin
          if (cnt_q >= last) begin
            state_d = BLINK_OFF;
            cnt_d   = '0;
            lvl_d   = 1'b0;
          end else begin
            cnt_d = cnt_q + CNT_WIDTH'(1);
          end
        end
        BLINK_OFF: begin
          if (cnt_q >= last) begin
            state_d = BLINK_ON;
            cnt_d   = '0;
            lvl_d   = 1'b1;
          end else begin
            cnt_d = cnt_q + CNT_WIDTH'(1);
          end
        end
        default: begin
          state_d = BLINK_ON;
          cnt_d   = '0;
          lvl_d   = 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge aclk) begin
    state_q <= state_d;
    cnt_q   <= cnt_d;
    lvl_q   <= lvl_d;
  end

  assign led_sts = lvl_q;

endmodule

// File: rtl/buzzer_led_driver.sv
// Three-channel RGB blink engine with LED pin polarity handling.
// Define BUZZER_LED_ACTIVE_LOW_EN for boards with active-low LEDs.
module buzzer_led_driver
  import buzzer_pkg::*;
#(
  parameter int CNT_WIDTH = BUZZER_CNT_WIDTH
) (
  input  logic                 aclk,
  input  logic                 aresetn,
  input  logic                 user_resetn,
  input  logic                 mode_r,
  input  logic                 mode_g,
  input  logic                 mode_b,
  input  logic                 enable_r,
  input  logic                 enable_g,
  input  logic                 enable_b,
  input  logic                 holded_r,
  input  logic                 holded_g,
  input  logic                 holded_b,
  input  logic [CNT_WIDTH-1:0] duration_r,
  input  logic [CNT_WIDTH-1:0] duration_g,
  input  logic [CNT_WIDTH-1:0] duration_b,
  output logic                 led_r,
  output logic                 led_g,
  output logic                 led_b,
  output logic                 led_r_sts,
  output logic                 led_g_sts,
  output logic                 led_b_sts
);

  buzzer_led_channel #(.CNT_WIDTH(CNT_WIDTH)) u_ch_r (
    .aclk        (aclk),
    .aresetn     (aresetn),
    .user_resetn (user_resetn),
    .mode        (mode_r),
    .enable      (enable_r),
    .holded      (holded_r),
    .duration    (duration_r),
    .led_sts     (led_r_sts)
  );

  buzzer_led_channel #(.CNT_WIDTH(CNT_WIDTH)) u_ch_g (
    .aclk        (aclk),
    .aresetn     (aresetn),
    .user_resetn (user_resetn),
    .mode        (mode_g),
    .enable      (enable_g),
    .holded      (holded_g),
    .duration    (duration_g),
    .led_sts     (led_g_sts)
  );

  buzzer_led_channel #(.CNT_WIDTH(CNT_WIDTH)) u_ch_b (
    .aclk        (aclk),
    .aresetn     (aresetn),
    .user_resetn (user_resetn),
    .mode        (mode_b),
    .enable      (enable_b),
    .holded      (holded_b),
    .duration    (duration_b),
    .led_sts     (led_b_sts)
  );

`ifdef BUZZER_LED_ACTIVE_LOW_EN
  assign led_r = ~led_r_sts;
  assign led_g = ~led_g_sts;
  assign led_b = ~led_b_sts;
`else
  assign led_r = led_r_sts;
  assign led_g = led_g_sts;
  assign led_b = led_b_sts;
`endif

endmodule

// File: tb/tb_buzzer_led_driver.sv
// Directed self-checking bench for buzzer_led_driver.
// Channel bit order in vectors is {r, g, b}.
module tb_buzzer_led_driver;

  logic        aclk = 1'b0;
  logic        aresetn;
  logic        user_resetn;
  logic [2:0]  en;
  logic [2:0]  mode;
  logic [2:0]  hold;
  logic [31:0] dur_r, dur_g, dur_b;
  logic        led_r, led_g, led_b;
  logic        led_r_sts, led_g_sts, led_b_sts;

  int checks   = 0;
  int failures = 0;

  always #5 aclk = ~aclk;

  buzzer_led_driver dut (
    .aclk        (aclk),
    .aresetn     (aresetn),
    .user_resetn (user_resetn),
    .mode_r      (mode[2]),
    .mode_g      (mode[1]),
    .mode_b      (mode[0]),
    .enable_r    (en[2]),
    .enable_g    (en[1]),
    .enable_b    (en[0]),
    .holded_r    (hold[2]),
    .holded_g    (hold[1]),
    .holded_b    (hold[0]),
    .duration_r  (dur_r),
    .duration_g  (dur_g),
    .duration_b  (dur_b),
    .led_r       (led_r),
    .led_g       (led_g),
    .led_b       (led_b),
    .led_r_sts   (led_r_sts),
    .led_g_sts   (led_g_sts),
    .led_b_sts   (led_b_sts)
  );

  typedef struct {
    logic       arst_n;
    logic       urst_n;
    logic [2:0] en;
    logic [2:0] mode;
    logic [2:0] hold;
    logic [2:0] sts;
  } vec_t;

  vec_t vecs[16];

  task automatic check(input string name, input logic [2:0] exp);
    logic [2:0] sts;
    logic [2:0] pins;
    logic [2:0] exp_pins;
    sts  = {led_r_sts, led_g_sts, led_b_sts};
    pins = {led_r, led_g, led_b};
`ifdef BUZZER_LED_ACTIVE_LOW_EN
    exp_pins = ~exp;
`else
    exp_pins = exp;
`endif
    checks++;
    if (sts !== exp) begin
      failures++;
      $display("FAIL %s sts: got=%b want=%b", name, sts, exp);
    end
    checks++;
    if (pins !== exp_pins) begin
      failures++;
      $display("FAIL %s pins: got=%b want=%b", name, pins, exp_pins);
    end
  endtask

  task automatic step();
    @(posedge aclk);
    #1;
  endtask

  task automatic do_reset();
    aresetn = 1'b0;
    step();
    step();
    check("reset", 3'b000);
    aresetn = 1'b1;
  endtask

  // Expected level of a blink that started with BLINK_ON at step k=0.
  function automatic logic blink_lvl(input int k, input int d);
    int de;
    de = (d == 0) ? 1 : d;
    return ((k / de) % 2) == 0;
  endfunction

  initial begin
    aresetn     = 1'b0;
    user_resetn = 1'b1;
    en          = 3'b000;
    mode        = 3'b000;
    hold        = 3'b000;
    dur_r       = 32'd10;
    dur_g       = 32'd4;
    dur_b       = 32'd1;

    //          arst  urst  en      mode    hold    sts
    vecs[0]  = '{1'b0, 1'b1, 3'b100, 3'b000, 3'b000, 3'b000};
    vecs[1]  = '{1'b0, 1'b1, 3'b100, 3'b000, 3'b000, 3'b000};
    vecs[2]  = '{1'b1, 1'b1, 3'b100, 3'b000, 3'b000, 3'b100};
    vecs[3]  = '{1'b1, 1'b1, 3'b110, 3'b000, 3'b000, 3'b110};
    vecs[4]  = '{1'b1, 1'b1, 3'b010, 3'b000, 3'b100, 3'b110};
    vecs[5]  = '{1'b1, 1'b1, 3'b000, 3'b000, 3'b100, 3'b100};
    vecs[6]  = '{1'b1, 1'b1, 3'b000, 3'b000, 3'b110, 3'b100};
    vecs[7]  = '{1'b1, 1'b0, 3'b000, 3'b000, 3'b110, 3'b000};
    vecs[8]  = '{1'b1, 1'b1, 3'b000, 3'b000, 3'b110, 3'b000};
    vecs[9]  = '{1'b1, 1'b1, 3'b001, 3'b000, 3'b000, 3'b001};
    vecs[10] = '{1'b1, 1'b1, 3'b001, 3'b001, 3'b000, 3'b001};
    vecs[11] = '{1'b1, 1'b1, 3'b001, 3'b001, 3'b000, 3'b000};
    vecs[12] = '{1'b1, 1'b1, 3'b001, 3'b001, 3'b000, 3'b001};
    vecs[13] = '{1'b1, 1'b1, 3'b000, 3'b001, 3'b001, 3'b001};
    vecs[14] = '{1'b1, 1'b1, 3'b000, 3'b001, 3'b001, 3'b001};
    vecs[15] = '{1'b1, 1'b1, 3'b000, 3'b001, 3'b000, 3'b000};

    for (int i = 0; i < 16; i++) begin
      aresetn     = vecs[i].arst_n;
      user_resetn = vecs[i].urst_n;
      en          = vecs[i].en;
      mode        = vecs[i].mode;
      hold        = vecs[i].hold;
      step();
      check($sformatf("vec%0d", i), vecs[i].sts);
    end

    // Green blink with duration 4.
    do_reset();
    dur_g = 32'd4;
    en    = 3'b010;
    mode  = 3'b010;
    hold  = 3'b000;
    for (int k = 0; k < 20; k++) begin
      step();
      check($sformatf("blink_g4_k%0d", k), {1'b0, blink_lvl(k, 4), 1'b0});
    end

    // Blue blink with degenerate durations 0 and 1.
    for (int d = 0; d < 2; d++) begin
      do_reset();
      dur_b = 32'(d);
      en    = 3'b001;
      mode  = 3'b001;
      for (int k = 0; k < 8; k++) begin
        step();
        check($sformatf("blink_b%0d_k%0d", d, k), {2'b00, blink_lvl(k, 1)});
      end
    end

    // Red hold while lit, then disable without hold.
    do_reset();
    dur_r = 32'd10;
    en    = 3'b100;
    mode  = 3'b100;
    hold  = 3'b100;
    for (int k = 0; k < 3; k++) step();
    en = 3'b000;
    for (int k = 0; k < 30; k++) begin
      step();
      if (k % 5 == 0) check($sformatf("hold_r_k%0d", k), 3'b100);
    end
    en = 3'b100;
    step();
    check("hold_exit_blink_on", 3'b100);
    step();
    step();
    en   = 3'b000;
    hold = 3'b000;
    step();
    check("unhold_off", 3'b000);
    step();
    check("unhold_off2", 3'b000);

    // Shrink green duration at count 50.
    do_reset();
    dur_g = 32'd100;
    en    = 3'b010;
    mode  = 3'b010;
    step();
    check("shrink_start", 3'b010);
    for (int k = 0; k < 50; k++) step();
    check("shrink_cnt50", 3'b010);
    dur_g = 32'd3;
    for (int k = 0; k < 12; k++) begin
      step();
      check($sformatf("shrink_k%0d", k), {1'b0, ((k / 3) % 2) == 1, 1'b0});
    end

    // user_resetn pulse with all channels blinking.
    do_reset();
    dur_r = 32'd2;
    dur_g = 32'd3;
    dur_b = 32'd5;
    en    = 3'b111;
    mode  = 3'b111;
    hold  = 3'b000;
    for (int k = 0; k < 4; k++) step();
    user_resetn = 1'b0;
    step();
    check("urst_all_off", 3'b000);
    user_resetn = 1'b1;
    for (int k = 0; k < 12; k++) begin
      step();
      check($sformatf("urst_restart_k%0d", k),
            {blink_lvl(k, 2), blink_lvl(k, 3), blink_lvl(k, 5)});
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
